// File: rtl/data_mem_pkg.sv
// data_mem_pkg: lane geometry, width clamp and host FSM states shared by the data memory.
package data_mem_pkg;
    localparam int NUM_LANES = 8;
    localparam int LANE_W = 8;
    typedef enum logic [1:0] {H_IDLE, H_ACK, H_DROP} host_state_t;
    function automatic logic [3:0] clamp_width(input logic [3:0] w);
        return (w > 4'd8) ? 4'd8 : w;
    endfunction
    function automatic logic [2:0] lane_bank(input logic [2:0] off, input logic [2:0] k);
        return off + k;
    endfunction
    function automatic logic [28:0] lane_row(input logic [31:0] addr, input logic [2:0] k);
        return 29'((addr + 32'(k)) >> 3);
    endfunction
endpackage

// File: rtl/mem_bank.sv
// mem_bank: one byte-wide single-port synchronous RAM with registered read data.
module mem_bank #(
    parameter int ROWS = 8192,
    parameter int ROW_W = 13
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem [ROWS];
    always_ff @(posedge clk) begin
        if (we) mem[row] <= wdata;
        rdata <= mem[row];
    end
endmodule

// File: rtl/data_mem.sv
// data_mem: byte-addressable 8-bank data memory with a priority proc port and a handshaked host port.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 65536,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_width_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [3:0]        host_width_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic [DATA_W-1:0] host_data_o,
    output logic              host_ack_o
);
    localparam int ROWS = DEPTH_BYTES / NUM_LANES;
    localparam int ROW_W = $clog2(ROWS);
    host_state_t state;
    logic host_go, acc, sel_we, proc_rd_q, host_rd_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0] sel_wid, wid_q;
    logic [2:0] off_q;
    logic [DATA_W-1:0] sel_data, rd_data, mem_q, host_q;
    logic [7:0] bank_rd [NUM_LANES];
    // Host access is gated by reset so an in-flight host write never commits.
    assign host_go = (state == H_IDLE) && host_req_i && !mem_ce_i && !rst;
    assign acc = mem_ce_i || host_go;
    assign sel_addr = mem_ce_i ? mem_addr_i : host_addr_i;
    assign sel_we = mem_ce_i ? mem_we_i : host_we_i;
    assign sel_wid = clamp_width(mem_ce_i ? mem_width_i : host_width_i);
    assign sel_data = mem_ce_i ? mem_data_i : host_data_i;
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_bank
        logic [2:0] k;
        logic [28:0] row_full;
        logic we;
        logic unused_row;
        assign k = 3'(b) - sel_addr[2:0];
        assign row_full = lane_row(32'(sel_addr), k);
        assign we = acc && sel_we && ({1'b0, k} < sel_wid);
        assign unused_row = ^row_full[28:ROW_W];
        mem_bank #(.ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
            .clk(clk),
            .we(we),
            .row(row_full[ROW_W-1:0]),
            .wdata(sel_data[LANE_W*k +: LANE_W]),
            .rdata(bank_rd[b])
        );
    end
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_LANES; k++)
            rd_data[LANE_W*k +: LANE_W] = (4'(k) < wid_q) ? bank_rd[lane_bank(off_q, 3'(k))] : 8'd0;
    end
    assign mem_data_o = proc_rd_q ? rd_data : mem_q;
    assign host_data_o = (host_ack_o && host_rd_q) ? rd_data : host_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= H_IDLE;
            host_ack_o <= 1'b0;
            proc_rd_q <= 1'b0;
            host_rd_q <= 1'b0;
            mem_q <= '0;
            host_q <= '0;
            off_q <= '0;
            wid_q <= '0;
        end else begin
            proc_rd_q <= mem_ce_i && !mem_we_i;
            host_rd_q <= host_go && !host_we_i;
            host_ack_o <= host_go;
            off_q <= sel_addr[2:0];
            wid_q <= sel_wid;
            if (proc_rd_q) mem_q <= rd_data;
            if (host_ack_o && host_rd_q) host_q <= rd_data;
            state <= (state == H_IDLE) ? (host_go ? H_ACK : H_IDLE) :
                     (state == H_ACK) ? H_DROP : (host_req_i ? H_DROP : H_IDLE);
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench for data_mem against a byte-array reference model.
module tb_data_mem;
    localparam int DEPTH = 65536;
    typedef struct {logic [63:0] exp; string name;} rd_t;
    logic clk = 0, rst = 1;
    logic mem_ce_i = 0, mem_we_i = 0, host_req_i = 0, host_we_i = 0;
    logic [31:0] mem_addr_i = 0, host_addr_i = 0;
    logic [3:0] mem_width_i = 0, host_width_i = 0;
    logic [63:0] mem_data_i = 0, host_data_i = 0;
    logic [63:0] mem_data_o, host_data_o;
    logic host_ack_o;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] model [int];
    rd_t rd_q[$];
    logic rd_issued = 0;

    data_mem dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_width_i(mem_width_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_width_i(host_width_i), .host_data_i(host_data_i), .host_data_o(host_data_o),
        .host_ack_o(host_ack_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    function automatic int eff(input logic [3:0] w);
        return (w > 4'd8) ? 8 : int'(w);
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [3:0] w, input logic [63:0] d);
        for (int k = 0; k < eff(w); k++) model[int'((a + 32'(k)) % DEPTH)] = d[8*k +: 8];
    endfunction

    function automatic logic [63:0] model_rd(input logic [31:0] a, input logic [3:0] w);
        logic [63:0] r = '0;
        for (int k = 0; k < eff(w); k++) r[8*k +: 8] = model[int'((a + 32'(k)) % DEPTH)];
        return r;
    endfunction

    // Scoreboard: a read accepted at a posedge is checked at the following negedge.
    always @(posedge clk) rd_issued <= mem_ce_i && !mem_we_i && !rst;
    always @(negedge clk) begin
        if (rd_issued) begin
            rd_t r;
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: got %h with no expected entry", mem_data_o);
            end else begin
                r = rd_q.pop_front();
                if (mem_data_o !== r.exp) begin
                    n_bad++;
                    $display("FAIL %s: mem_data_o=%h expected=%h", r.name, mem_data_o, r.exp);
                end
            end
        end
    end

    task automatic cycle_wr(input logic [31:0] a, input logic [3:0] w, input logic [63:0] d);
        @(negedge clk);
        mem_ce_i = 1; mem_we_i = 1; mem_addr_i = a; mem_width_i = w; mem_data_i = d;
        model_wr(a, w, d);
    endtask

    task automatic cycle_rd(input logic [31:0] a, input logic [3:0] w, input logic [63:0] e, input string nm);
        @(negedge clk);
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = a; mem_width_i = w;
        rd_q.push_back('{exp: e, name: nm});
    endtask

    task automatic cycle_idle();
        @(negedge clk);
        mem_ce_i = 0; mem_we_i = 0;
    endtask

    task automatic host_txn(input logic we, input logic [31:0] a, input logic [3:0] w, input logic [63:0] d,
                            input int extra, output int acks, output logic [63:0] rd);
        @(negedge clk);
        host_req_i = 1; host_we_i = we; host_addr_i = a; host_width_i = w; host_data_i = d;
        acks = 0; rd = 'x;
        for (int i = 0; i < 4 + extra; i++) begin
            @(negedge clk);
            if (host_ack_o) begin
                acks++;
                rd = host_data_o;
            end
        end
        host_req_i = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp += 3;
        if (mem_data_o !== 64'd0) begin n_bad++; $display("FAIL reset_mem_data: got %h expected 0", mem_data_o); end
        if (host_data_o !== 64'd0) begin n_bad++; $display("FAIL reset_host_data: got %h expected 0", host_data_o); end
        if (host_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", host_ack_o); end
        rst = 0;
    endtask

    task automatic test_unaligned();
        cycle_wr(32'd3, 4'd4, 64'hDEADBEEF);
        cycle_rd(32'd4, 4'd2, 64'hADBE, "rd_w2_a4");
        cycle_idle();
        @(negedge clk);
        n_cmp++;
        if (mem_data_o !== 64'hADBE) begin n_bad++; $display("FAIL read_hold: got %h expected %h", mem_data_o, 64'hADBE); end
    endtask

    task automatic test_row_span();
        cycle_wr(32'h0F, 4'd8, 64'h0807060504030201);
        cycle_rd(32'h16, 4'd1, 64'h08, "rd_w1_a16");
        cycle_rd(32'h0F, 4'd8, 64'h0807060504030201, "rd_w8_a0f");
        cycle_idle();
    endtask

    task automatic test_width_clamp();
        cycle_rd(32'h0F, 4'd0, 64'd0, "rd_w0");
        cycle_wr(32'h0, 4'd8, 64'h1122334455667788);
        cycle_rd(32'h0, 4'd12, 64'h1122334455667788, "rd_w12_clamp");
        cycle_wr(32'h0F, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle_rd(32'h0F, 4'd1, 64'h01, "wr_w0_noop");
        cycle_idle();
    endtask

    task automatic test_host_stall();
        for (int i = 0; i < 5; i++) begin
            cycle_rd(32'd3, 4'd1, model_rd(32'd3, 4'd1), "stall_rd");
            if (i == 0) begin
                host_req_i = 1; host_we_i = 1; host_addr_i = 32'h100; host_width_i = 4'd2; host_data_i = 64'hCAFE;
            end
            n_cmp++;
            if (host_ack_o !== 1'b0) begin n_bad++; $display("FAIL stall_no_ack: cycle %0d ack=%b expected 0", i, host_ack_o); end
        end
        cycle_idle();
        model_wr(32'h100, 4'd2, 64'hCAFE);
        n_cmp++;
        if (host_ack_o !== 1'b0) begin n_bad++; $display("FAIL stall_last: ack=%b expected 0", host_ack_o); end
        @(negedge clk);
        n_cmp++;
        if (host_ack_o !== 1'b1) begin n_bad++; $display("FAIL ack_after_ce_drop: ack=%b expected 1", host_ack_o); end
        @(negedge clk);
        n_cmp++;
        if (host_ack_o !== 1'b0) begin n_bad++; $display("FAIL ack_pulse_width: ack=%b expected 0", host_ack_o); end
        host_req_i = 0;
        @(negedge clk);
        cycle_rd(32'h100, 4'd2, 64'hCAFE, "proc_sees_host_wr");
        cycle_idle();
    endtask

    task automatic test_host_hold();
        int acks;
        logic [63:0] rd;
        host_txn(1'b1, 32'h200, 4'd2, 64'h0123, 10, acks, rd);
        model_wr(32'h200, 4'd2, 64'h0123);
        n_cmp++;
        if (acks !== 1) begin n_bad++; $display("FAIL held_req_one_ack: acks=%0d expected 1", acks); end
        host_txn(1'b0, 32'h100, 4'd2, 64'd0, 10, acks, rd);
        n_cmp += 2;
        if (acks !== 1) begin n_bad++; $display("FAIL host_read_ack: acks=%0d expected 1", acks); end
        if (rd !== 64'hCAFE) begin n_bad++; $display("FAIL host_read_data: got %h expected %h", rd, 64'hCAFE); end
        n_cmp++;
        if (host_data_o !== 64'hCAFE) begin n_bad++; $display("FAIL host_data_hold: got %h expected %h", host_data_o, 64'hCAFE); end
        host_txn(1'b1, 32'h202, 4'd1, 64'h55, 0, acks, rd);
        model_wr(32'h202, 4'd1, 64'h55);
        n_cmp++;
        if (host_data_o !== 64'hCAFE) begin n_bad++; $display("FAIL host_wr_keeps_data: got %h expected %h", host_data_o, 64'hCAFE); end
        cycle_rd(32'h200, 4'd3, 64'h550123, "proc_after_host_wr");
        cycle_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        host_req_i = 1; host_we_i = 1; host_addr_i = 32'h100; host_width_i = 4'd2; host_data_i = 64'hBEEF;
        rst = 1;
        @(negedge clk);
        n_cmp += 3;
        if (host_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_no_ack: ack=%b expected 0", host_ack_o); end
        if (mem_data_o !== 64'd0) begin n_bad++; $display("FAIL rst_mem_data: got %h expected 0", mem_data_o); end
        if (host_data_o !== 64'd0) begin n_bad++; $display("FAIL rst_host_data: got %h expected 0", host_data_o); end
        rst = 0; host_req_i = 0;
        @(negedge clk);
        n_cmp++;
        if (host_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_no_late_ack: ack=%b expected 0", host_ack_o); end
        cycle_rd(32'h100, 4'd2, 64'hCAFE, "preload_after_rst");
        cycle_rd(32'(DEPTH + 3), 4'd1, model_rd(32'd3, 4'd1), "addr_wrap");
        cycle_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [3:0] w;
        for (int p = 0; p < 'h48; p += 8) cycle_wr(32'(p), 4'd8, {$urandom, $urandom});
        cycle_wr(32'(DEPTH - 8), 4'd8, {$urandom, $urandom});
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 1) ? 32'($urandom_range(0, 64)) : 32'(DEPTH - 8 + $urandom_range(0, 7));
            w = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1)) cycle_wr(a, w, {$urandom, $urandom});
            else cycle_rd(a, w, model_rd(a, w), "b2b_rd");
        end
        cycle_rd(32'(DEPTH - 3), 4'd8, model_rd(32'(DEPTH - 3), 4'd8), "b2b_top_wrap");
        cycle_idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unaligned();
        test_row_span();
        test_width_clamp();
        test_host_stall();
        test_host_hold();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (rd_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", rd_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
